// File: rtl/cache_pkg.sv
// cache_pkg: shared types and address-field helpers for the data cache
package cache_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, REFILL, WRITE} dc_state_t;
    function automatic int tag_w(input int lines, input int words);
        return WORD_W - 2 - $clog2(lines) - $clog2(words);
    endfunction
endpackage

// File: rtl/dcache_storage.sv
// dcache_storage: valid/tag/data arrays, one combinational read port, synchronous write ports
module dcache_storage
    import cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    localparam int IW = $clog2(LINES),
    localparam int WB = $clog2(WORDS),
    localparam int TW = tag_w(LINES, WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     rd_index,
    input  logic [WB-1:0]     rd_word,
    output logic              rd_valid,
    output logic [TW-1:0]     rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic [IW-1:0]     wr_index,
    input  logic              fill_en,
    input  logic [WB-1:0]     fill_word,
    input  logic [WORD_W-1:0] fill_data,
    input  logic              tag_en,
    input  logic [TW-1:0]     tag_data,
    input  logic              st_en,
    input  logic [IW-1:0]     st_index,
    input  logic [WB-1:0]     st_word,
    input  logic [WORD_W-1:0] st_data
);
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tags [LINES];
    logic [WORD_W-1:0] data [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (reset) valid <= '0;
        else if (tag_en) valid[wr_index] <= 1'b1;
    end

    // tag and data contents are meaningless until valid is set, so they need no reset
    always_ff @(posedge clk) begin
        if (tag_en) tags[wr_index] <= tag_data;
        if (fill_en) data[wr_index][fill_word] <= fill_data;
        else if (st_en) data[st_index][st_word] <= st_data;
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index][rd_word];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-through no-write-allocate data cache
// with a word-wide memory handshake; stalls the core on misses and stores
module dcache_controller
    import cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int IW = $clog2(LINES);
    localparam int WB = $clog2(WORDS);
    localparam int TW = tag_w(LINES, WORDS);
    localparam int LO = WB + 2;

    dc_state_t     state, state_nx;
    logic [WB-1:0] cnt;
    logic [31:0]   cap_addr, cap_wdata, lk_addr;
    logic          rd_valid, hit, last, fill_en, tag_en, st_en;
    logic [TW-1:0] rd_tag;
    logic [31:0]   rd_data;
    logic          unused_bits;

    // a pending store looks up its captured address, everything else the live request
    assign lk_addr     = state == WRITE ? cap_addr : addr;
    assign hit         = rd_valid && rd_tag == lk_addr[31-:TW];
    assign last        = cnt == WB'(WORDS - 1);
    assign unused_bits = ^{addr[1:0], lk_addr[1:0]};

    dcache_storage #(.LINES(LINES), .WORDS(WORDS)) u_storage (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (lk_addr[LO+:IW]),
        .rd_word   (lk_addr[2+:WB]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (cap_addr[LO+:IW]),
        .fill_en   (fill_en),
        .fill_word (cnt),
        .fill_data (mem_rdata),
        .tag_en    (tag_en),
        .tag_data  (cap_addr[31-:TW]),
        .st_en     (st_en),
        .st_index  (cap_addr[LO+:IW]),
        .st_word   (cap_addr[2+:WB]),
        .st_data   (cap_wdata)
    );

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        rdata     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_en   = 1'b0;
        tag_en    = 1'b0;
        st_en     = 1'b0;
        case (state)
            IDLE: begin
                stall    = MemWrite || (MemRead && !hit);
                rdata    = (MemRead && !MemWrite && hit) ? rd_data : '0;
                state_nx = MemWrite ? WRITE : (MemRead && !hit) ? REFILL : IDLE;
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {cap_addr[31:LO], cnt, 2'b00};
                fill_en  = mem_ready && !reset;
                tag_en   = fill_en && last;
                state_nx = (mem_ready && last) ? IDLE : REFILL;
            end
            WRITE: begin
                stall     = !mem_ready;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                st_en     = mem_ready && hit && !reset;
                state_nx  = mem_ready ? IDLE : WRITE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                cap_addr  <= MemWrite ? {addr[31:2], 2'b00} : {addr[31:LO], LO'(0)};
                cap_wdata <= wdata;
                cnt       <= '0;
            end else if (state == REFILL && mem_ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
